// File: rtl/sobel_gradient_stream_pkg.sv
// rtl/sobel_gradient_stream_pkg.sv - Sobel kernels, direction enum and tangent constants
package sobel_gradient_stream_pkg;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } dir_e;

    // Tap i = row*3+col, row 0 at the top, col 0 at the left
    localparam int SOBEL_X [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int SOBEL_Y [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    // tan(22.5deg) ~= 2/5 and tan(67.5deg) ~= 5/2 bound the diagonal sectors
    localparam int TAN_NUM = 2;
    localparam int TAN_DEN = 5;

endpackage

// File: rtl/sobel_gradient_stream_isqrt.sv
// rtl/sobel_gradient_stream_isqrt.sv - combinational floor integer square root (digit recurrence)
module isqrt_comb #(
    parameter  int IN_W  = 21,
    localparam int OUT_W = (IN_W + 1) / 2
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] root
);

    logic [2*OUT_W-1:0] din_pad;
    logic [OUT_W+1:0]   rem;
    logic [OUT_W+1:0]   trial;
    logic [OUT_W-1:0]   q;

    // One result bit per pair of input bits, MSB first; rem never exceeds 2*q
    always_comb begin
        din_pad = (2*OUT_W)'(din);
        rem     = '0;
        trial   = '0;
        q       = '0;
        for (int i = OUT_W - 1; i >= 0; i--) begin
            rem   = {rem[OUT_W-1:0], din_pad[2*i +: 2]};
            trial = {q, 2'b01};
            if (rem >= trial) begin
                rem = rem - trial;
                q   = {q[OUT_W-2:0], 1'b1};
            end else begin
                q   = {q[OUT_W-2:0], 1'b0};
            end
        end
        root = q;
    end

endmodule

// File: rtl/sobel_gradient_stream.sv
// rtl/sobel_gradient_stream.sv - 4-stage Sobel magnitude/edge/direction pipeline; GRAD_DIR_EN enables direction
module sobel_gradient_stream
    import sobel_gradient_stream_pkg::*;
#(
    parameter  int PIX_W = 8,
    parameter  int CNT_W = 20,
    localparam int G_W   = PIX_W + 3,
    localparam int MAG_W = PIX_W + 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [9*PIX_W-1:0] in_window,
    input  logic               in_sof,
    input  logic [MAG_W-1:0]   cfg_thresh,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAG_W-1:0]   out_mag,
    output logic [1:0]         out_dir,
    output logic               out_edge,
    output logic               out_sof,
    output logic [CNT_W-1:0]   edge_count
);

    localparam int A_W   = G_W - 1;
    localparam int SQ_W  = 2*G_W - 2;
    localparam int SUM_W = 2*G_W - 1;
    localparam int D_W   = G_W + 2;

    logic adv;

    logic signed [G_W-1:0] gx_c, gy_c, pix_s;
    logic                  s1_valid, s1_sof;
    logic signed [G_W-1:0] s1_gx, s1_gy;

    logic [A_W-1:0]        ax_c, ay_c;
    logic                  s2_valid, s2_sof;
    logic [SQ_W-1:0]       s2_gx2, s2_gy2;

    logic                  s3_valid, s3_sof;
    logic [SUM_W-1:0]      s3_sum;

    logic [MAG_W-1:0]      mag_c;

    // Whole pipeline moves as one; bubbles are carried, not squeezed
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    function automatic logic [A_W-1:0] abs_g(input logic signed [G_W-1:0] v);
        return v[G_W-1] ? (~v[A_W-1:0] + A_W'(1)) : v[A_W-1:0];
    endfunction

    // Pixels are unsigned; G_W leaves headroom so partial sums never wrap
    always_comb begin
        gx_c  = '0;
        gy_c  = '0;
        pix_s = '0;
        for (int i = 0; i < 9; i++) begin
            pix_s = signed'(G_W'(in_window[i*PIX_W +: PIX_W]));
            gx_c  = gx_c + signed'(G_W'(SOBEL_X[i])) * pix_s;
            gy_c  = gy_c + signed'(G_W'(SOBEL_Y[i])) * pix_s;
        end
    end

    assign ax_c = abs_g(s1_gx);
    assign ay_c = abs_g(s1_gy);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_gx    <= '0;
            s1_gy    <= '0;
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_gx2   <= '0;
            s2_gy2   <= '0;
            s3_valid <= 1'b0;
            s3_sof   <= 1'b0;
            s3_sum   <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_sof   <= in_sof;
            s1_gx    <= gx_c;
            s1_gy    <= gy_c;
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_gx2   <= SQ_W'(ax_c) * SQ_W'(ax_c);
            s2_gy2   <= SQ_W'(ay_c) * SQ_W'(ay_c);
            s3_valid <= s2_valid;
            s3_sof   <= s2_sof;
            s3_sum   <= SUM_W'(s2_gx2) + SUM_W'(s2_gy2);
        end
    end

    isqrt_comb #(
        .IN_W (SUM_W)
    ) u_isqrt (
        .din  (s3_sum),
        .root (mag_c)
    );

    // Threshold is sampled as the result enters S4, so in-flight flags never change
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_edge  <= 1'b0;
            out_sof   <= 1'b0;
        end else if (adv) begin
            out_valid <= s3_valid;
            out_mag   <= mag_c;
            out_edge  <= (mag_c > cfg_thresh);
            out_sof   <= s3_sof;
        end
    end

`ifdef GRAD_DIR_EN
    dir_e dir_c, s2_dir, s3_dir, out_dir_q;

    // Both components are non-zero whenever the diagonal branches are reached
    always_comb begin
        dir_c = DIR_0;
        if (D_W'(TAN_DEN) * D_W'(ay_c) <= D_W'(TAN_NUM) * D_W'(ax_c))
            dir_c = DIR_0;
        else if (D_W'(TAN_NUM) * D_W'(ay_c) >= D_W'(TAN_DEN) * D_W'(ax_c))
            dir_c = DIR_90;
        else if (s1_gx[G_W-1] == s1_gy[G_W-1])
            dir_c = DIR_45;
        else
            dir_c = DIR_135;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_dir    <= DIR_0;
            s3_dir    <= DIR_0;
            out_dir_q <= DIR_0;
        end else if (adv) begin
            s2_dir    <= dir_c;
            s3_dir    <= s2_dir;
            out_dir_q <= s3_dir;
        end
    end

    assign out_dir = out_dir_q;
`else
    assign out_dir = DIR_0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_count <= '0;
        end else if (out_valid && out_ready) begin
            if (out_sof)
                edge_count <= CNT_W'(out_edge);
            else if (out_edge && (edge_count != '1))
                edge_count <= edge_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sobel_gradient_stream.sv
// tb/tb_sobel_gradient_stream.sv - self-checking bench for sobel_gradient_stream
module tb_sobel_gradient_stream;

    localparam int PIX_W = 8;
    localparam int MAG_W = PIX_W + 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [9*PIX_W-1:0] in_window;
    logic               in_sof;
    logic [MAG_W-1:0]   cfg_thresh;
    logic               out_valid;
    logic               out_ready;
    logic [MAG_W-1:0]   out_mag;
    logic [1:0]         out_dir;
    logic               out_edge;
    logic               out_sof;
    logic [19:0]        edge_count;

    logic               in_ready_s;
    logic               out_valid_s;
    logic [MAG_W-1:0]   out_mag_s;
    logic [1:0]         out_dir_s;
    logic               out_edge_s;
    logic               out_sof_s;
    logic [1:0]         edge_count_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int mag;
        int dir;
        bit edg;
        bit sof;
    } exp_t;

    exp_t sb[$];
    int   ec;
    int   ec_s;

    always #5 clk = ~clk;

    sobel_gradient_stream #(.PIX_W(PIX_W), .CNT_W(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_window  (in_window),
        .in_sof     (in_sof),
        .cfg_thresh (cfg_thresh),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mag    (out_mag),
        .out_dir    (out_dir),
        .out_edge   (out_edge),
        .out_sof    (out_sof),
        .edge_count (edge_count)
    );

    sobel_gradient_stream #(.PIX_W(PIX_W), .CNT_W(2)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_s),
        .in_window  (in_window),
        .in_sof     (in_sof),
        .cfg_thresh (cfg_thresh),
        .out_valid  (out_valid_s),
        .out_ready  (out_ready),
        .out_mag    (out_mag_s),
        .out_dir    (out_dir_s),
        .out_edge   (out_edge_s),
        .out_sof    (out_sof_s),
        .edge_count (edge_count_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    function automatic exp_t model(input logic [9*PIX_W-1:0] w, input int thr, input bit sof);
        exp_t e;
        int p[9];
        int gx, gy, s, m, ax, ay;
        for (int i = 0; i < 9; i++) p[i] = int'(w[i*PIX_W +: PIX_W]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        s  = gx*gx + gy*gy;
        m  = 0;
        while ((m + 1) * (m + 1) <= s) m++;
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        if (gx == 0 && gy == 0)      e.dir = 0;
        else if (5*ay <= 2*ax)       e.dir = 0;
        else if (2*ay >= 5*ax)       e.dir = 2;
        else if ((gx > 0) == (gy > 0)) e.dir = 1;
        else                         e.dir = 3;
`ifndef GRAD_DIR_EN
        e.dir = 0;
`endif
        e.mag = m;
        e.edg = (m > thr);
        e.sof = sof;
        return e;
    endfunction

    function automatic logic [9*PIX_W-1:0] pack9(input int a0, input int a1, input int a2,
                                                 input int a3, input int a4, input int a5,
                                                 input int a6, input int a7, input int a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic int dir_req(input int d);
`ifdef GRAD_DIR_EN
        return d;
`else
        return 0 * d;
`endif
    endfunction

    // Runs one clock: scoreboard compares in the current cycle, then advances
    task automatic tick();
        exp_t e;
        #1;
        if (rst) begin
            sb.delete();
            ec   = 0;
            ec_s = 0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_mag", 32'(out_mag), 32'(sb[0].mag));
                    chk("out_dir", 32'(out_dir), 32'(sb[0].dir));
                    chk("out_edge", 32'(out_edge), 32'(sb[0].edg));
                    chk("out_sof", 32'(out_sof), 32'(sb[0].sof));
                end
                if (!out_ready) chk("in_ready_stalled", 32'(in_ready), 32'd0);
            end
            chk("edge_count", 32'(edge_count), 32'(ec));
            chk("edge_count_small", 32'(edge_count_s), 32'(ec_s));
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sof) begin
                    ec   = int'(e.edg);
                    ec_s = int'(e.edg);
                end else begin
                    if (e.edg && ec < (1 << 20) - 1) ec++;
                    if (e.edg && ec_s < 3) ec_s++;
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_window, int'(cfg_thresh), in_sof));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        tick();
    endtask

    task automatic send_one(input logic [9*PIX_W-1:0] w, input int mag, input int dir, input bit edg);
        in_window = w;
        in_sof    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("latency_early", 32'(out_valid), 32'd0);
        tick();
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("dir_mag", 32'(out_mag), 32'(mag));
        chk("dir_dir", 32'(out_dir), 32'(dir_req(dir)));
        chk("dir_edge", 32'(out_edge), 32'(edg));
        tick();
    endtask

    initial begin
        logic [9*PIX_W-1:0] stall_win [8];
        logic [95:0]        r;
        int                 pat [10] = '{1, 0, 1, 1, 0, 1, 0, 1, 1, 0};
        int                 idx;
        int                 c;
        bit                 acc;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_window  = '0;
        in_sof     = 1'b0;
        cfg_thresh = 11'd30;
        out_ready  = 1'b1;
        ec         = 0;
        ec_s       = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_mag", 32'(out_mag), 32'd0);
        chk("rst_edge_count", 32'(edge_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        send_one({9{8'h80}}, 0, 0, 1'b0);
        send_one(pack9(0, 0, 255, 0, 0, 255, 0, 0, 255), 1020, 0, 1'b1);
        send_one(pack9(0, 0, 0, 0, 0, 0, 255, 255, 255), 1020, 2, 1'b1);
        send_one(pack9(0, 0, 0, 0, 0, 0, 0, 0, 255), 360, 1, 1'b1);
        send_one(pack9(0, 0, 255, 0, 0, 0, 0, 0, 0), 360, 3, 1'b1);
        cfg_thresh = 11'd360;
        send_one(pack9(0, 0, 0, 0, 0, 0, 0, 0, 255), 360, 1, 1'b0);
        cfg_thresh = 11'd359;
        send_one(pack9(0, 0, 0, 0, 0, 0, 0, 0, 255), 360, 1, 1'b1);
        cfg_thresh = 11'd30;

        for (int k = 0; k < 8; k++) begin
            r = {$urandom(), $urandom(), $urandom()};
            stall_win[k] = r[9*PIX_W-1:0];
        end
        idx = 0;
        c   = 0;
        while (idx < 8 && c < 60) begin
            in_valid  = 1'b1;
            in_sof    = 1'b0;
            in_window = stall_win[idx];
            out_ready = !(c >= 4 && c < 9);
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            c++;
        end
        chk("stall_all_accepted", 32'(idx), 32'd8);
        drain(40);

        for (int k = 0; k < 10; k++) begin
            in_window = (pat[k] != 0) ? pack9(0, 0, 255, 0, 0, 255, 0, 0, 255) : {9{8'h80}};
            in_sof    = (k == 0);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            tick();
        end
        drain(20);
        chk("frame_edge_count", 32'(edge_count), 32'd6);
        chk("frame_edge_count_sat", 32'(edge_count_s), 32'd3);
        in_window = {9{8'h80}};
        in_sof    = 1'b1;
        in_valid  = 1'b1;
        tick();
        drain(20);
        chk("new_frame_count", 32'(edge_count), 32'd0);
        chk("new_frame_count_small", 32'(edge_count_s), 32'd0);

        cfg_thresh = 11'd200;
        for (int k = 0; k < 300; k++) begin
            r = {$urandom(), $urandom(), $urandom()};
            in_window = r[9*PIX_W-1:0];
            in_valid  = ($urandom_range(9) < 7);
            in_sof    = ($urandom_range(7) == 0);
            out_ready = ($urandom_range(9) < 7);
            tick();
        end
        drain(40);

        for (int k = 0; k < 3; k++) begin
            r = {$urandom(), $urandom(), $urandom()};
            in_window = r[9*PIX_W-1:0];
            in_valid  = 1'b1;
            in_sof    = (k == 0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_edge_count", 32'(edge_count), 32'd0);
        for (int k = 0; k < 6; k++) tick();
        chk("midrst_no_leak", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
